// File: rtl/register_files_pkg.sv
// Shared types and helpers for the register file family: clear FSM states and
// the address-width rule used to size every address port.
package register_files_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

    // A single-entry file still needs a one-bit address bus.
    function automatic int addr_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: address mux, optional same-edge write bypass
// (enabled by defining REGFILE_BYPASS_EN), and valid/busy output registers.
module register_file_read_port
    import register_files_pkg::*;
#(
    parameter int NUM_ADDRESS = 16,
    parameter int DATA_LENGTH = 32,
    parameter int AW          = addr_width(NUM_ADDRESS)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic [AW-1:0]                             address,
    input  logic [NUM_ADDRESS-1:0][DATA_LENGTH-1:0]   mem,
    input  logic [NUM_ADDRESS-1:0]                    busy,
    input  logic [NUM_ADDRESS-1:0]                    wr_hit,
    input  logic [NUM_ADDRESS-1:0][DATA_LENGTH-1:0]   wr_data,
    input  logic [NUM_ADDRESS-1:0]                    busy_next,
    output logic [DATA_LENGTH-1:0]                    data_out,
    output logic                                      valid,
    output logic                                      busy_out
);

    logic [DATA_LENGTH-1:0] sel_data;
    logic                   sel_busy;

    // Addresses with no matching entry fall through to zero data, not busy.
`ifdef REGFILE_BYPASS_EN
    always_comb begin
        sel_data = '0;
        sel_busy = 1'b0;
        for (int a = 0; a < NUM_ADDRESS; a++) begin
            if (address == AW'(a)) begin
                sel_data = wr_hit[a] ? wr_data[a]   : mem[a];
                sel_busy = wr_hit[a] ? busy_next[a] : busy[a];
            end
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_hit, wr_data, busy_next};

    always_comb begin
        sel_data = '0;
        sel_busy = 1'b0;
        for (int a = 0; a < NUM_ADDRESS; a++) begin
            if (address == AW'(a)) begin
                sel_data = mem[a];
                sel_busy = busy[a];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            valid    <= 1'b0;
            busy_out <= 1'b0;
        end else begin
            valid <= enable;
            if (enable) begin
                data_out <= sel_data;
                busy_out <= sel_busy;
            end
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Multi-port register file with busy scoreboard and sequenced clear engine.
// Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module multiport_register_file
    import register_files_pkg::*;
#(
    parameter int NUM_ADDRESS     = 16,
    parameter int DATA_LENGTH     = 32,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int AW              = addr_width(NUM_ADDRESS)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_WRITE_PORTS-1:0]                    write_enable,
    input  logic [NUM_WRITE_PORTS-1:0][AW-1:0]            write_address,
    input  logic [NUM_WRITE_PORTS-1:0][DATA_LENGTH-1:0]   write_data_in,
    output logic                                          write_ready,
    input  logic [NUM_READ_PORTS-1:0]                     read_enable,
    input  logic [NUM_READ_PORTS-1:0][AW-1:0]             read_address,
    output logic [NUM_READ_PORTS-1:0][DATA_LENGTH-1:0]    read_data_out,
    output logic [NUM_READ_PORTS-1:0]                     read_valid,
    output logic [NUM_READ_PORTS-1:0]                     read_busy,
    input  logic                                          reserve_enable,
    input  logic [AW-1:0]                                 reserve_address,
    input  logic                                          clear_start,
    output logic                                          clear_busy,
    output logic                                          clear_done,
    output logic                                          clear_state
);

    clear_state_e                            state;
    logic [AW-1:0]                           idx;
    logic [NUM_ADDRESS-1:0][DATA_LENGTH-1:0] mem;
    logic [NUM_ADDRESS-1:0][DATA_LENGTH-1:0] wr_data;
    logic [NUM_ADDRESS-1:0]                  wr_hit;
    logic [NUM_ADDRESS-1:0]                  busy;
    logic [NUM_ADDRESS-1:0]                  busy_next;
    logic                                    start_clear;

    assign write_ready = ~clear_busy;
    assign clear_state = (state == CLEAR);
    assign start_clear = (state == IDLE) && clear_start;

    // Ascending port scan: the highest-numbered matching port overrides.
    always_comb begin
        wr_hit  = '0;
        wr_data = '0;
        for (int a = 0; a < NUM_ADDRESS; a++) begin
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (write_ready && write_enable[p] && write_address[p] == AW'(a)) begin
                    wr_hit[a]  = 1'b1;
                    wr_data[a] = write_data_in[p];
                end
            end
        end
    end

    // A reserve outranks both the sweep start and a write to the same entry.
    always_comb begin
        busy_next = busy;
        for (int a = 0; a < NUM_ADDRESS; a++) begin
            if (start_clear || wr_hit[a])
                busy_next[a] = 1'b0;
            if (reserve_enable && reserve_address == AW'(a))
                busy_next[a] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        idx        <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx == AW'(NUM_ADDRESS - 1)) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
        end else begin
            for (int a = 0; a < NUM_ADDRESS; a++) begin
                if (state == CLEAR) begin
                    if (idx == AW'(a))
                        mem[a] <= '0;
                end else if (wr_hit[a]) begin
                    mem[a] <= wr_data[a];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_read
        register_file_read_port #(
            .NUM_ADDRESS (NUM_ADDRESS),
            .DATA_LENGTH (DATA_LENGTH),
            .AW          (AW)
        ) u_port (
            .clk       (clk),
            .reset     (reset),
            .enable    (read_enable[g]),
            .address   (read_address[g]),
            .mem       (mem),
            .busy      (busy),
            .wr_hit    (wr_hit),
            .wr_data   (wr_data),
            .busy_next (busy_next),
            .data_out  (read_data_out[g]),
            .valid     (read_valid[g]),
            .busy_out  (read_busy[g])
        );
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a model.
module tb_multiport_register_file;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NW-1:0]          write_enable;
    logic [NW-1:0][AW-1:0]  write_address;
    logic [NW-1:0][DW-1:0]  write_data_in;
    logic                   write_ready;
    logic [NR-1:0]          read_enable;
    logic [NR-1:0][AW-1:0]  read_address;
    logic [NR-1:0][DW-1:0]  read_data_out;
    logic [NR-1:0]          read_valid;
    logic [NR-1:0]          read_busy;
    logic                   reserve_enable;
    logic [AW-1:0]          reserve_address;
    logic                   clear_start;
    logic                   clear_busy;
    logic                   clear_done;
    logic                   clear_state;

    int checks = 0;
    int errors = 0;

    multiport_register_file #(
        .NUM_ADDRESS     (N),
        .DATA_LENGTH     (DW),
        .NUM_READ_PORTS  (NR),
        .NUM_WRITE_PORTS (NW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .write_enable    (write_enable),
        .write_address   (write_address),
        .write_data_in   (write_data_in),
        .write_ready     (write_ready),
        .read_enable     (read_enable),
        .read_address    (read_address),
        .read_data_out   (read_data_out),
        .read_valid      (read_valid),
        .read_busy       (read_busy),
        .reserve_enable  (reserve_enable),
        .reserve_address (reserve_address),
        .clear_start     (clear_start),
        .clear_busy      (clear_busy),
        .clear_done      (clear_done),
        .clear_state     (clear_state)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: array of entries, busy flags, sweep position
    logic [DW-1:0] m_mem [N];
    bit            m_busy [N];
    bit            m_clearing;
    int            m_pos;
    bit            m_done;
    logic [DW-1:0] m_rd_data [NR];
    bit            m_rd_valid [NR];
    bit            m_rd_busy [NR];
    bit            m_was_clearing;
    bit            m_hit;
    logic [DW-1:0] m_wd;
    int            m_a;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < N; a++) begin
                m_mem[a]  = '0;
                m_busy[a] = 1'b0;
            end
            for (int r = 0; r < NR; r++) begin
                m_rd_data[r]  = '0;
                m_rd_valid[r] = 1'b0;
                m_rd_busy[r]  = 1'b0;
            end
            m_clearing = 1'b0;
            m_pos      = 0;
            m_done     = 1'b0;
        end else begin
            m_was_clearing = m_clearing;
            for (int r = 0; r < NR; r++) begin
                m_rd_valid[r] = read_enable[r];
                if (read_enable[r]) begin
                    m_a   = int'(read_address[r]);
                    m_hit = 1'b0;
                    m_wd  = '0;
                    for (int p = 0; p < NW; p++)
                        if (!m_was_clearing && write_enable[p] && int'(write_address[p]) == m_a) begin
                            m_hit = 1'b1;
                            m_wd  = write_data_in[p];
                        end
`ifdef REGFILE_BYPASS_EN
                    if (m_hit) begin
                        m_rd_data[r] = m_wd;
                        m_rd_busy[r] = reserve_enable && int'(reserve_address) == m_a;
                    end else begin
                        m_rd_data[r] = m_mem[m_a];
                        m_rd_busy[r] = m_busy[m_a];
                    end
`else
                    m_rd_data[r] = m_mem[m_a];
                    m_rd_busy[r] = m_busy[m_a];
`endif
                end
            end
            if (!m_was_clearing && clear_start)
                for (int a = 0; a < N; a++) m_busy[a] = 1'b0;
            if (!m_was_clearing)
                for (int p = 0; p < NW; p++)
                    if (write_enable[p]) begin
                        m_mem[write_address[p]]  = write_data_in[p];
                        m_busy[write_address[p]] = 1'b0;
                    end
            if (reserve_enable)
                m_busy[reserve_address] = 1'b1;
            if (m_was_clearing) begin
                m_mem[m_pos] = '0;
                m_done = (m_pos == N - 1);
                if (m_done) m_clearing = 1'b0;
                else        m_pos++;
            end else begin
                m_done = 1'b0;
                if (clear_start) begin
                    m_clearing = 1'b1;
                    m_pos      = 0;
                end
            end
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int r = 0; r < NR; r++) begin
                chk($sformatf("read_valid[%0d]", r), 64'(read_valid[r]), 64'(m_rd_valid[r]));
                chk($sformatf("read_data[%0d]", r), 64'(read_data_out[r]), 64'(m_rd_data[r]));
                chk($sformatf("read_busy[%0d]", r), 64'(read_busy[r]), 64'(m_rd_busy[r]));
            end
            chk("clear_busy", 64'(clear_busy), 64'(m_clearing));
            chk("clear_done", 64'(clear_done), 64'(m_done));
            chk("write_ready", 64'(write_ready), 64'(!m_clearing));
            chk("clear_state", 64'(clear_state), 64'(m_clearing));
        end
    end

    // driver tasks
    task automatic idle();
        write_enable    = '0;
        write_address   = '0;
        write_data_in   = '0;
        read_enable     = '0;
        read_address    = '0;
        reserve_enable  = 1'b0;
        reserve_address = '0;
        clear_start     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        write_enable[p]  = 1'b1;
        write_address[p] = AW'(a);
        write_data_in[p] = d;
    endtask

    task automatic rd(input int p, input int a);
        read_enable[p]  = 1'b1;
        read_address[p] = AW'(a);
    endtask

    logic [DW-1:0] bypass_exp;
    int busy_cnt;
    int done_cnt;

    initial begin
        idle();
        repeat (3) tick();
        chk("rst_read_valid", 64'(read_valid), 64'(0));
        chk("rst_read_data", 64'(read_data_out), 64'(0));
        chk("rst_write_ready", 64'(write_ready), 64'(1));
        chk("rst_clear_busy", 64'(clear_busy), 64'(0));
        reset = 1'b1;
        tick();

        // write then read on the other port
        wr(0, 3, 32'hDEADBEEF);
        tick(); idle();
        rd(1, 3);
        tick(); idle();
        chk("rd_after_wr_data", 64'(read_data_out[1]), 64'(32'hDEADBEEF));
        chk("rd_after_wr_valid", 64'(read_valid[1]), 64'(1));
        tick();
        chk("valid_drops", 64'(read_valid[1]), 64'(0));
        chk("data_holds", 64'(read_data_out[1]), 64'(32'hDEADBEEF));

        // same-address write collision: port 1 wins
        wr(0, 5, 32'h11); wr(1, 5, 32'h22);
        tick(); idle();
        rd(0, 5);
        tick(); idle();
        chk("collision_hi_port", 64'(read_data_out[0]), 64'(32'h22));

        // same-edge read and write
        wr(0, 7, 32'h1);
        tick(); idle();
        wr(1, 7, 32'hABCD); rd(0, 7);
        tick(); idle();
`ifdef REGFILE_BYPASS_EN
        bypass_exp = 32'hABCD;
`else
        bypass_exp = 32'h1;
`endif
        chk("same_edge_read", 64'(read_data_out[0]), 64'(bypass_exp));

        // scoreboard
        reserve_enable = 1'b1; reserve_address = 4'd2;
        tick(); idle();
        rd(0, 2);
        tick(); idle();
        chk("reserve_sets_busy", 64'(read_busy[0]), 64'(1));
        wr(0, 2, 32'h99);
        tick(); idle();
        rd(0, 2);
        tick(); idle();
        chk("write_clears_busy", 64'(read_busy[0]), 64'(0));
        reserve_enable = 1'b1; reserve_address = 4'd9; wr(1, 9, 32'h77);
        tick(); idle();
        rd(1, 9);
        tick(); idle();
        chk("reserve_beats_write", 64'(read_busy[1]), 64'(1));
        chk("reserve_write_data", 64'(read_data_out[1]), 64'(32'h77));

        // randomized traffic, including occasional sweeps
        for (int i = 0; i < 1500; i++) begin
            write_enable    = NW'($urandom_range(0, 3));
            for (int p = 0; p < NW; p++) begin
                write_address[p] = AW'($urandom_range(0, N - 1));
                write_data_in[p] = $urandom;
            end
            read_enable     = NR'($urandom_range(0, 3));
            for (int r = 0; r < NR; r++)
                read_address[r] = AW'($urandom_range(0, N - 1));
            reserve_enable  = ($urandom_range(0, 3) == 0);
            reserve_address = AW'($urandom_range(0, N - 1));
            clear_start     = ($urandom_range(0, 149) == 0);
            tick();
        end
        idle();
        repeat (20) tick();

        // fill, then full sweep with a dropped mid-sweep write
        for (int a = 0; a < N; a++) begin
            wr(a % 2, a, 32'h1000 + 32'(a));
            tick(); idle();
        end
        clear_start = 1'b1;
        tick(); idle();
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
            if (i == 4) wr(0, 15, 32'h55);
            tick(); idle();
        end
        chk("sweep_busy_cycles", 64'(busy_cnt), 64'(16));
        chk("sweep_done_pulses", 64'(done_cnt), 64'(1));
        for (int a = 0; a < N; a++) begin
            rd(a % 2, a);
            tick(); idle();
            chk($sformatf("swept_entry_%0d", a), 64'(read_data_out[a % 2]), 64'(0));
        end

        // reset in the middle of a sweep
        for (int a = 0; a < 8; a++) begin
            wr(0, a, 32'hF0 + 32'(a));
            tick(); idle();
        end
        clear_start = 1'b1;
        tick(); idle();
        repeat (5) tick();
        rd(0, 7); rd(1, 7);
        tick(); idle();
        chk("pre_reset_valid", 64'(read_valid), 64'(2'b11));
        #1 reset = 1'b0;
        #1;
        chk("midclear_rst_clear_busy", 64'(clear_busy), 64'(0));
        chk("midclear_rst_write_ready", 64'(write_ready), 64'(1));
        chk("midclear_rst_valid", 64'(read_valid), 64'(0));
        chk("midclear_rst_data", 64'(read_data_out), 64'(0));
        chk("midclear_rst_busy", 64'(read_busy), 64'(0));
        chk("midclear_rst_state", 64'(clear_state), 64'(0));
        chk("midclear_rst_done", 64'(clear_done), 64'(0));
        @(posedge clk); #2;
        reset = 1'b1;
        tick();
        chk("post_rst_ready", 64'(write_ready), 64'(1));
        chk("post_rst_state", 64'(clear_state), 64'(0));
        rd(0, 7); rd(1, 3);
        tick(); idle();
        chk("post_rst_entry7", 64'(read_data_out[0]), 64'(0));
        chk("post_rst_entry3", 64'(read_data_out[1]), 64'(0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
